// File: rtl/snake_map_if.sv
// Snake core bundle: renderer query, player controls, apple position and status.
interface snake_map_if;
  logic [3:0] dir_in;
  logic       start;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic [1:0] snake;
  logic       apple_eat;
  logic       game_over;
  logic [4:0] length;

  modport master (
    output dir_in, start, x_pos, y_pos, apple_x, apple_y,
    input  snake, apple_eat, game_over, length
  );

  modport slave (
    input  dir_in, start, x_pos, y_pos, apple_x, apple_y,
    output snake, apple_eat, game_over, length
  );
endinterface

// File: rtl/snake_map.sv
// Snake game-state core: segment list, stepping, collisions, growth and cell query.
module snake_map #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned STEP_DIV = 12500000
) (
  input logic        clk,
  input logic        clr,
  snake_map_if.slave bus
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned LEN_W = 5;
  localparam int unsigned CX_W  = 6;
  localparam int unsigned CY_W  = 5;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam logic [1:0] CELL_NONE = 2'b00;
  localparam logic [1:0] CELL_HEAD = 2'b01;
  localparam logic [1:0] CELL_BODY = 2'b10;
  localparam logic [1:0] CELL_WALL = 2'b11;

  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              do_move, do_init;

  logic [3:0]        dir, pend, dir_mv;
  logic [CX_W-1:0]   seg_x [MAX_LEN];
  logic [CY_W-1:0]   seg_y [MAX_LEN];
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  lim;

  logic [CX_W-1:0]   nh_x;
  logic [CY_W-1:0]   nh_y;
  logic              eat_c, hit_c;

  logic [5:0]        cx, cy;
  logic              body_c;
  logic [1:0]        cell_c;

  logic [1:0]        snake_r;
  logic              apple_eat_r;
  logic              game_over_r;

  // Reverse of a one-hot direction: up<->down, left<->right.
  function automatic logic [3:0] rev_dir(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // Candidate move: resolved direction, next head, apple hit and collision.
  always_comb begin
    dir_mv = (pend == rev_dir(dir)) ? dir : pend;
    nh_x   = seg_x[0];
    nh_y   = seg_y[0];
    if (dir_mv[3])      nh_y = seg_y[0] - CY_W'(1);
    else if (dir_mv[2]) nh_y = seg_y[0] + CY_W'(1);
    else if (dir_mv[1]) nh_x = seg_x[0] - CX_W'(1);
    else                nh_x = seg_x[0] + CX_W'(1);
    eat_c = (nh_x == bus.apple_x) && (nh_y == bus.apple_y);
    // The tail cell is vacated by the move unless the snake grows.
    lim   = eat_c ? len_r : len_r - LEN_W'(1);
    hit_c = (nh_x == CX_W'(0)) || (nh_x >= CX_W'(39)) ||
            (nh_y == CY_W'(0)) || (nh_y >= CY_W'(29));
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < lim) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
        hit_c = 1'b1;
    end
  end

  // Pixel-to-cell lookup with WALL > HEAD > BODY > NONE priority.
  always_comb begin
    cx     = bus.x_pos[9:4];
    cy     = bus.y_pos[9:4];
    body_c = 1'b0;
    for (int i = 1; i < int'(MAX_LEN); i++) begin
      if ((LEN_W'(i) < len_r) && (seg_x[i] == cx) && ({1'b0, seg_y[i]} == cy))
        body_c = 1'b1;
    end
    cell_c = CELL_NONE;
    if ((bus.x_pos < 10'd640) && (bus.y_pos < 10'd480)) begin
      if ((cx == 6'd0) || (cx == 6'd39) || (cy == 6'd0) || (cy == 6'd29))
        cell_c = CELL_WALL;
      else if ((seg_x[0] == cx) && ({1'b0, seg_y[0]} == cy))
        cell_c = CELL_HEAD;
      else if (body_c)
        cell_c = CELL_BODY;
    end
  end

  // FSM state and step counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state, step timing and move/reinit strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    do_move   = 1'b0;
    do_init   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = PLAY;
      end
      PLAY: begin
        if (cnt == CNT_W'(STEP_DIV - 1)) begin
          cnt_nxt = '0;
          if (hit_c) state_nxt = DEAD;
          else       do_move   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DEAD: begin
        if (bus.start) begin
          state_nxt = IDLE;
          do_init   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Segment list, direction, length and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x[i] <= CX_W'(20 - i);
        seg_y[i] <= CY_W'(15);
      end
      len_r       <= LEN_W'(INIT_LEN);
      dir         <= DIR_RIGHT;
      pend        <= DIR_RIGHT;
      snake_r     <= CELL_NONE;
      apple_eat_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      if ($onehot(bus.dir_in)) pend <= bus.dir_in;
      snake_r     <= cell_c;
      apple_eat_r <= do_move & eat_c;
      game_over_r <= (state_nxt == DEAD);
      if (do_init) begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
          seg_x[i] <= CX_W'(20 - i);
          seg_y[i] <= CY_W'(15);
        end
        len_r <= LEN_W'(INIT_LEN);
        dir   <= DIR_RIGHT;
      end else if (do_move) begin
        for (int i = 1; i < int'(MAX_LEN); i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nh_x;
        seg_y[0] <= nh_y;
        dir      <= dir_mv;
        if (eat_c && (len_r < LEN_W'(MAX_LEN))) len_r <= len_r + LEN_W'(1);
      end
    end
  end

  assign bus.snake     = snake_r;
  assign bus.apple_eat = apple_eat_r;
  assign bus.game_over = game_over_r;
  assign bus.length    = len_r;

endmodule

// File: tb/tb_snake_map.sv
// Bench for snake_map: queue-based game model, per-cycle compare, directed and random play.
module tb_snake_map;

  localparam int MAXL  = 16;
  localparam int INITL = 3;
  localparam int SDIV  = 4;

  logic clk;
  logic clr;
  snake_map_if sif();

  snake_map #(.MAX_LEN(MAXL), .INIT_LEN(INITL), .STEP_DIV(SDIV)) dut (
    .clk(clk),
    .clr(clr),
    .bus(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: snake as a queue of cells, head first; directions 0 up,1 down,2 left,3 right.
  int mx[$];
  int my[$];
  int m_state;  // 0 idle, 1 play, 2 dead
  int m_cyc, m_dir, m_pend, m_len;
  int e_snake, e_eat, e_go;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cell_of(input int x, input int y);
    int cx, cy;
    if (x >= 640 || y >= 480) return 0;
    cx = x / 16;
    cy = y / 16;
    if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 3;
    if (mx[0] == cx && my[0] == cy) return 1;
    for (int k = 1; k < m_len; k++)
      if (mx[k] == cx && my[k] == cy) return 2;
    return 0;
  endfunction

  task automatic model_restart();
    mx.delete();
    my.delete();
    for (int k = 0; k < INITL; k++) begin
      mx.push_back(20 - k);
      my.push_back(15);
    end
    m_len = INITL;
    m_dir = 3;
    m_cyc = 0;
  endtask

  task automatic model_reset();
    model_restart();
    m_pend  = 3;
    m_state = 0;
    e_snake = 0;
    e_eat   = 0;
    e_go    = 0;
  endtask

  task automatic model_move();
    int d, nx, ny, lim;
    bit eat, hit;
    d  = (m_pend == (m_dir ^ 1)) ? m_dir : m_pend;
    nx = mx[0];
    ny = my[0];
    case (d)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
    eat = (nx == int'(sif.apple_x)) && (ny == int'(sif.apple_y));
    hit = (nx <= 0) || (nx >= 39) || (ny <= 0) || (ny >= 29);
    lim = eat ? m_len : m_len - 1;
    for (int k = 0; k < lim; k++)
      if (mx[k] == nx && my[k] == ny) hit = 1'b1;
    if (hit) begin
      m_state = 2;
      return;
    end
    m_dir = d;
    mx.push_front(nx);
    my.push_front(ny);
    if (eat && m_len < MAXL) m_len++;
    else begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    e_eat = eat ? 1 : 0;
  endtask

  function automatic int dir_idx(input logic [3:0] d);
    if (d[3]) return 0;
    if (d[2]) return 1;
    if (d[1]) return 2;
    return 3;
  endfunction

  // Model advance on each clock edge, reset on clr.
  always @(posedge clk or posedge clr) begin
    if (clr) model_reset();
    else begin
      e_snake = cell_of(int'(sif.x_pos), int'(sif.y_pos));
      e_eat   = 0;
      case (m_state)
        0: if (sif.start) begin m_state = 1; m_cyc = 0; end
        1: begin
          if (m_cyc == SDIV - 1) begin
            m_cyc = 0;
            model_move();
          end else m_cyc++;
        end
        default: if (sif.start) begin model_restart(); m_state = 0; end
      endcase
      if ($countones(sif.dir_in) == 1) m_pend = dir_idx(sif.dir_in);
      e_go = (m_state == 2) ? 1 : 0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      #1;
      check("snake", int'(sif.snake), e_snake);
      check("apple_eat", int'(sif.apple_eat), e_eat);
      check("game_over", int'(sif.game_over), e_go);
      check("length", int'(sif.length), m_len);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic query(input string name, input int x, input int y, input int exp);
    sif.x_pos = 10'(x);
    sif.y_pos = 10'(y);
    cyc(1);
    check(name, int'(sif.snake), exp);
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    cyc(1);
    sif.start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic set_apple(input int ax, input int ay);
    sif.apple_x = 6'(ax);
    sif.apple_y = 5'(ay);
  endtask

  initial begin
    int r, k, ax, ay;
    clr = 1'b1;
    sif.start  = 1'b0;
    sif.dir_in = 4'b0001;
    sif.x_pos  = '0;
    sif.y_pos  = '0;
    set_apple(5, 5);
    cyc(2);
    #1;
    check("rst_length", int'(sif.length), 3);
    check("rst_game_over", int'(sif.game_over), 0);
    check("rst_snake", int'(sif.snake), 0);
    clr = 1'b0;
    chk_en = 1'b1;

    // Idle queries on the initial snake.
    query("q_head", 320, 240, 1);
    query("q_body", 304, 240, 2);
    query("q_wall", 0, 100, 3);
    query("q_offscreen", 700, 10, 0);
    query("q_cell17", 272, 240, 0);

    // First move lands STEP_DIV cycles after start.
    pulse_start();
    sif.x_pos = 10'd336;
    sif.y_pos = 10'd240;
    cyc(4);
    check("pre_move_cell21", int'(sif.snake), 0);
    cyc(1);
    check("post_move_head21", int'(sif.snake), 1);
    query("body19", 304, 240, 2);
    query("tail_gone18", 288, 240, 0);

    // Eating grows the snake by one and pulses once.
    pulse_clr();
    set_apple(21, 15);
    pulse_start();
    cyc(4);
    check("eat_pulse", int'(sif.apple_eat), 1);
    check("eat_length", int'(sif.length), 4);
    query("eat_head21", 336, 240, 1);
    check("eat_pulse_once", int'(sif.apple_eat), 0);
    query("eat_tail18", 288, 240, 2);
    cyc(2);
    check("no_second_pulse", int'(sif.apple_eat), 0);
    check("len_kept", int'(sif.length), 4);

    // clr mid-play restores reset state and stops motion.
    pulse_clr();
    check("clr_length", int'(sif.length), 3);
    check("clr_game_over", int'(sif.game_over), 0);
    sif.x_pos = 10'd320;
    sif.y_pos = 10'd240;
    cyc(10);
    check("clr_head20", int'(sif.snake), 1);
    query("clr_no_motion", 336, 240, 0);

    // Run into the right wall, then restart.
    set_apple(5, 5);
    pulse_start();
    cyc(75);
    check("alive_at_38", int'(sif.game_over), 0);
    cyc(1);
    check("dead_at_wall", int'(sif.game_over), 1);
    query("dead_head38", 608, 240, 1);
    pulse_start();
    check("restart_go", int'(sif.game_over), 0);
    query("restart_head20", 320, 240, 1);
    query("restart_cell38", 608, 240, 0);

    // Reverse request ignored; invalid code keeps pending up.
    pulse_clr();
    pulse_start();
    cyc(6);
    sif.dir_in = 4'b0010;
    cyc(1);
    sif.dir_in = 4'b0000;
    cyc(1);
    query("reverse_ignored", 352, 240, 1);
    sif.dir_in = 4'b1000;
    cyc(1);
    sif.dir_in = 4'b0101;
    cyc(2);
    query("turn_up", 352, 224, 1);

    // Random play against the model.
    pulse_clr();
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14) sif.dir_in = 4'(1 << $urandom_range(0, 3));
      else if (r < 17) sif.dir_in = 4'b0000;
      else sif.dir_in = 4'($urandom);
      sif.start = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) begin
        ax = mx[0] + int'($urandom_range(0, 4)) - 2;
        ay = my[0] + int'($urandom_range(0, 4)) - 2;
        if (ax < 0) ax = 0;
        if (ax > 39) ax = 39;
        if (ay < 0) ay = 0;
        if (ay > 29) ay = 29;
        set_apple(ax, ay);
      end
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        k = int'($urandom_range(0, mx.size() - 1));
        sif.x_pos = 10'(mx[k] * 16 + int'($urandom_range(0, 15)));
        sif.y_pos = 10'(my[k] * 16 + int'($urandom_range(0, 15)));
      end else if (r < 8) begin
        sif.x_pos = 10'($urandom_range(0, 1023));
        sif.y_pos = 10'($urandom_range(0, 1023));
      end else begin
        sif.x_pos = 10'($urandom_range(0, 639));
        sif.y_pos = 10'($urandom_range(0, 479));
      end
      cyc(1);
    end
    clr = 1'b0;
    sif.start = 1'b0;
    cyc(2);
    chk_en = 1'b0;
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
